color_centroid_tracker: RTL and testbench

- Consumes the camera VGA stream plus the per-pixel x/y position from the pixel position counter.
- Classifies each valid pixel against a runtime RGB colour window and accumulates the x sum, y sum and hit count of matching pixels over one frame.
- At each frame end, snapshots the accumulators and runs a sequential restoring divider to produce the centroid of the tracked colour.
- Feeds the overlay/servo stages downstream.

---
 rtl/color_centroid_tracker.sv | 241 ++++++++++++++++++++++++
 tb/tb_color_centroid_tracker.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/color_centroid_tracker.sv
// Colour centroid tracker.
// Classifies each valid pixel against a runtime RGB window and accumulates the
// x sum, y sum and hit count of matching pixels over a frame. At every falling
// edge of VS the accumulators are snapshotted and a restoring divider produces
// the centroid of the tracked colour for the overlay and servo stages.
module color_centroid_tracker #(
  parameter int POS_W      = 13,
  parameter int CNT_W      = 24,
  parameter int SUM_W      = POS_W + CNT_W,
  parameter int MIN_PIXELS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             iVGA_VS,
  input  logic             iVGA_BLANK_N,
  input  logic [7:0]       iVGA_R,
  input  logic [7:0]       iVGA_G,
  input  logic [7:0]       iVGA_B,
  input  logic [POS_W-1:0] x_pos,
  input  logic [POS_W-1:0] y_pos,
  input  logic [7:0]       r_min,
  input  logic [7:0]       r_max,
  input  logic [7:0]       g_min,
  input  logic [7:0]       g_max,
  input  logic [7:0]       b_min,
  input  logic [7:0]       b_max,
  output logic [POS_W-1:0] centroid_x,
  output logic [POS_W-1:0] centroid_y,
  output logic [CNT_W-1:0] pixel_total,
  output logic             found,
  output logic             result_valid,
  output logic             busy
);

  localparam int               ITER_W    = $clog2(SUM_W + 1);
  localparam int               STEP_W    = CNT_W + SUM_W;
  localparam logic [CNT_W-1:0] MIN_CNT   = CNT_W'(MIN_PIXELS);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [SUM_W-1:0] SUM_ZERO  = {SUM_W{1'b0}};
  localparam logic [ITER_W-1:0] ITER_FULL = ITER_W'(SUM_W);
  localparam logic [ITER_W-1:0] ITER_ONE  = ITER_W'(1);
  localparam logic [POS_W-1:0] POS_ZERO  = {POS_W{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One restoring-division step. The numerator register holds the remaining
  // dividend bits at the top and collects quotient bits at the bottom, so after
  // SUM_W steps it contains the full quotient. The remainder always stays
  // below den, so CNT_W bits suffice between steps.
  function automatic logic [STEP_W-1:0] div_step(
    input logic [CNT_W-1:0] rem,
    input logic [SUM_W-1:0] num,
    input logic [CNT_W-1:0] den
  );
    logic [CNT_W:0] trial;
    logic [CNT_W:0] diff;
    logic           qbit;
    trial = {rem, num[SUM_W-1]};
    if (trial >= {1'b0, den}) begin
      diff = trial - {1'b0, den};
      qbit = 1'b1;
    end else begin
      diff = trial;
      qbit = 1'b0;
    end
    div_step = {diff[CNT_W-1:0], num[SUM_W-2:0], qbit};
  endfunction

  state_t              state_r;
  state_t              state_next_s;
  logic                vs_d_r;
  logic [SUM_W-1:0]    sum_x_r;
  logic [SUM_W-1:0]    sum_y_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [SUM_W-1:0]    num_x_r;
  logic [SUM_W-1:0]    num_y_r;
  logic [CNT_W-1:0]    rem_x_r;
  logic [CNT_W-1:0]    rem_y_r;
  logic [CNT_W-1:0]    den_r;
  logic [ITER_W-1:0]   iter_r;

  logic                r_ok_s;
  logic                g_ok_s;
  logic                b_ok_s;
  logic                hit_s;
  logic                frame_end_s;
  logic                sat_s;
  logic                below_s;
  logic [STEP_W-1:0]   step_x_s;
  logic [STEP_W-1:0]   step_y_s;

  // An inverted window (min > max) can never satisfy both bounds, so it
  // naturally yields no hits.
  assign r_ok_s      = (iVGA_R >= r_min) && (iVGA_R <= r_max);
  assign g_ok_s      = (iVGA_G >= g_min) && (iVGA_G <= g_max);
  assign b_ok_s      = (iVGA_B >= b_min) && (iVGA_B <= b_max);
  assign hit_s       = iVGA_VS && iVGA_BLANK_N && r_ok_s && g_ok_s && b_ok_s;
  assign frame_end_s = vs_d_r && !iVGA_VS;
  assign sat_s       = (cnt_r == CNT_MAX);
  assign below_s     = (cnt_r < MIN_CNT) || (cnt_r == CNT_ZERO);
  assign step_x_s    = div_step(rem_x_r, num_x_r, den_r);
  assign step_y_s    = div_step(rem_y_r, num_y_r, den_r);

  // Delay VS for frame-end detection and accumulate matching pixels; a
  // saturated count freezes the sums too so they stay consistent with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      vs_d_r  <= 1'b1;
      sum_x_r <= SUM_ZERO;
      sum_y_r <= SUM_ZERO;
      cnt_r   <= CNT_ZERO;
    end else begin
      vs_d_r <= iVGA_VS;
      if (frame_end_s) begin
        sum_x_r <= SUM_ZERO;
        sum_y_r <= SUM_ZERO;
        cnt_r   <= CNT_ZERO;
      end else if (hit_s && !sat_s) begin
        sum_x_r <= sum_x_r + {{(SUM_W-POS_W){1'b0}}, x_pos};
        sum_y_r <= sum_y_r + {{(SUM_W-POS_W){1'b0}}, y_pos};
        cnt_r   <= cnt_r + CNT_ONE;
      end else begin
        sum_x_r <= sum_x_r;
        sum_y_r <= sum_y_r;
        cnt_r   <= cnt_r;
      end
    end
  end

  // State register of the divide controller.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: frames below the hit threshold skip the divide.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (frame_end_s) begin
          if (below_s) begin
            state_next_s = DONE;
          end else begin
            state_next_s = DIV;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      DIV: begin
        if (iter_r == ITER_ONE) begin
          state_next_s = DONE;
        end else begin
          state_next_s = DIV;
        end
      end
      DONE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Snapshot, divider iterations and registered result outputs. Results are
  // loaded on the edge entering DONE so they are valid with result_valid.
  // A frame end outside IDLE is ignored here; its data is simply lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      num_x_r      <= SUM_ZERO;
      num_y_r      <= SUM_ZERO;
      rem_x_r      <= CNT_ZERO;
      rem_y_r      <= CNT_ZERO;
      den_r        <= CNT_ZERO;
      iter_r       <= {ITER_W{1'b0}};
      centroid_x   <= POS_ZERO;
      centroid_y   <= POS_ZERO;
      pixel_total  <= CNT_ZERO;
      found        <= 1'b0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (frame_end_s) begin
            num_x_r <= sum_x_r;
            num_y_r <= sum_y_r;
            rem_x_r <= CNT_ZERO;
            rem_y_r <= CNT_ZERO;
            den_r   <= cnt_r;
            iter_r  <= ITER_FULL;
            if (below_s) begin
              centroid_x   <= POS_ZERO;
              centroid_y   <= POS_ZERO;
              pixel_total  <= cnt_r;
              found        <= 1'b0;
              result_valid <= 1'b1;
              busy         <= 1'b0;
            end else begin
              busy <= 1'b1;
            end
          end
        end
        DIV: begin
          rem_x_r <= step_x_s[STEP_W-1:SUM_W];
          num_x_r <= step_x_s[SUM_W-1:0];
          rem_y_r <= step_y_s[STEP_W-1:SUM_W];
          num_y_r <= step_y_s[SUM_W-1:0];
          iter_r  <= iter_r - ITER_ONE;
          if (iter_r == ITER_ONE) begin
            centroid_x   <= step_x_s[POS_W-1:0];
            centroid_y   <= step_y_s[POS_W-1:0];
            pixel_total  <= den_r;
            found        <= (den_r >= MIN_CNT);
            result_valid <= 1'b1;
            busy         <= 1'b0;
          end
        end
        DONE: begin
          busy <= 1'b0;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_color_centroid_tracker.sv
// Directed bench for color_centroid_tracker: a default build and a CNT_W=8
// build share one stimulus stream; a pixel-level model pushes expected results
// to per-build queues which a monitor pops on result_valid.
`timescale 1ns/1ps
module tb_color_centroid_tracker;

  localparam int POS_W  = 13;
  localparam int CNT_W  = 24;
  localparam int CNT8_W = 8;
  localparam int LAT    = POS_W + CNT_W;
  localparam int LAT8   = POS_W + CNT8_W;
  localparam int MINP   = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             vs, blank_n;
  logic [7:0]       r, g, b;
  logic [POS_W-1:0] xp, yp;
  logic [7:0]       r_min, r_max, g_min, g_max, b_min, b_max;

  logic [POS_W-1:0]  cx, cy, cx8, cy8;
  logic [CNT_W-1:0]  total;
  logic [CNT8_W-1:0] total8;
  logic              found, found8, valid, valid8, busy, busy8;

  color_centroid_tracker dut (
    .clk(clk), .reset(reset), .iVGA_VS(vs), .iVGA_BLANK_N(blank_n),
    .iVGA_R(r), .iVGA_G(g), .iVGA_B(b), .x_pos(xp), .y_pos(yp),
    .r_min(r_min), .r_max(r_max), .g_min(g_min), .g_max(g_max),
    .b_min(b_min), .b_max(b_max),
    .centroid_x(cx), .centroid_y(cy), .pixel_total(total), .found(found),
    .result_valid(valid), .busy(busy)
  );

  color_centroid_tracker #(.CNT_W(CNT8_W)) dut8 (
    .clk(clk), .reset(reset), .iVGA_VS(vs), .iVGA_BLANK_N(blank_n),
    .iVGA_R(r), .iVGA_G(g), .iVGA_B(b), .x_pos(xp), .y_pos(yp),
    .r_min(r_min), .r_max(r_max), .g_min(g_min), .g_max(g_max),
    .b_min(b_min), .b_max(b_max),
    .centroid_x(cx8), .centroid_y(cy8), .pixel_total(total8), .found(found8),
    .result_valid(valid8), .busy(busy8)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     cyc;
    longint cx;
    longint cy;
    longint total;
    bit     found;
  } exp_t;

  exp_t   q_main[$];
  exp_t   q_8[$];
  int     tests = 0;
  int     fails = 0;
  longint sx, sy, sc, sx8, sy8, sc8;
  int     idle_from, idle_from8;
  bit     prev_vs;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit model_hit(input bit v, input bit bl, input logic [7:0] rr,
                                   input logic [7:0] gg, input logic [7:0] bb);
    return v && bl && (rr >= r_min) && (rr <= r_max) && (gg >= g_min) &&
           (gg <= g_max) && (bb >= b_min) && (bb <= b_max);
  endfunction

  // Model of the frame end: push a result only if that build's divider is idle.
  task automatic frame_end_model();
    exp_t it;
    int   e;
    e = cyc + 1;
    if (e >= idle_from) begin
      it.total = sc;
      if (sc < MINP) begin
        it.cx = 0; it.cy = 0; it.found = 1'b0; it.cyc = e;
      end else begin
        it.cx = sx / sc; it.cy = sy / sc; it.found = 1'b1; it.cyc = e + LAT;
      end
      q_main.push_back(it);
      idle_from = it.cyc + 2;
    end
    if (e >= idle_from8) begin
      it.total = sc8;
      if (sc8 < MINP) begin
        it.cx = 0; it.cy = 0; it.found = 1'b0; it.cyc = e;
      end else begin
        it.cx = sx8 / sc8; it.cy = sy8 / sc8; it.found = 1'b1; it.cyc = e + LAT8;
      end
      q_8.push_back(it);
      idle_from8 = it.cyc + 2;
    end
    sx = 0; sy = 0; sc = 0; sx8 = 0; sy8 = 0; sc8 = 0;
  endtask

  task automatic pix(input bit v, input bit bl, input logic [7:0] rr, input logic [7:0] gg,
                     input logic [7:0] bb, input int x, input int y);
    @(negedge clk);
    vs = v; blank_n = bl; r = rr; g = gg; b = bb;
    xp = POS_W'(x); yp = POS_W'(y);
    if (prev_vs && !v) begin
      frame_end_model();
    end else if (model_hit(v, bl, rr, gg, bb)) begin
      sx += x; sy += y; sc++;
      if (sc8 != 255) begin
        sx8 += x; sy8 += y; sc8++;
      end
    end
    prev_vs = v;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) pix(1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 0, 0);
  endtask

  task automatic vs_low(input int n);
    for (int i = 0; i < n; i++) pix(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 0, 0);
  endtask

  // Raster over [x0..x1]x[y0..y1]; up to 'limit' pixels inside the block get
  // the given colour, everything else is black.
  task automatic scan(input int x0, input int x1, input int y0, input int y1,
                      input int bx0, input int bx1, input int by0, input int by1,
                      input int limit, input logic [7:0] rr, input logic [7:0] gg,
                      input logic [7:0] bb);
    int painted;
    painted = 0;
    for (int y = y0; y <= y1; y++) begin
      for (int x = x0; x <= x1; x++) begin
        if (x >= bx0 && x <= bx1 && y >= by0 && y <= by1 && painted < limit) begin
          pix(1'b1, 1'b1, rr, gg, bb, x, y);
          painted++;
        end else begin
          pix(1'b1, 1'b1, 8'd0, 8'd0, 8'd0, x, y);
        end
      end
    end
  endtask

  task automatic set_window(input logic [7:0] rl, input logic [7:0] rh, input logic [7:0] gl,
                            input logic [7:0] gh, input logic [7:0] bl, input logic [7:0] bh);
    r_min = rl; r_max = rh; g_min = gl; g_max = gh; b_min = bl; b_max = bh;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q_main.size() != 0 || q_8.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 64'(q_main.size() + q_8.size()), 64'd0);
    idle(3);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1; vs = 1'b1; blank_n = 1'b0;
    q_main.delete(); q_8.delete();
    sx = 0; sy = 0; sc = 0; sx8 = 0; sy8 = 0; sc8 = 0;
    idle_from = 0; idle_from8 = 0; prev_vs = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_cx"}, 64'(cx), 64'd0);
    check({tag, "_cy"}, 64'(cy), 64'd0);
    check({tag, "_total"}, 64'(total), 64'd0);
    check({tag, "_found"}, 64'(found), 64'd0);
    check({tag, "_valid"}, 64'(valid), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_cx8"}, 64'(cx8), 64'd0);
    check({tag, "_cy8"}, 64'(cy8), 64'd0);
    check({tag, "_total8"}, 64'(total8), 64'd0);
    check({tag, "_found8"}, 64'(found8), 64'd0);
    check({tag, "_valid8"}, 64'(valid8), 64'd0);
    check({tag, "_busy8"}, 64'(busy8), 64'd0);
  endtask

  // Scoreboard monitor: every result_valid pulse must match the queue head.
  always @(negedge clk) begin
    exp_t it;
    if (valid === 1'b1) begin
      if (q_main.size() == 0) begin
        check("main_unexpected_valid", 64'(valid), 64'd0);
      end else begin
        it = q_main.pop_front();
        check("main_latency", 64'(cyc), 64'(it.cyc));
        check("main_cx", 64'(cx), 64'(it.cx));
        check("main_cy", 64'(cy), 64'(it.cy));
        check("main_total", 64'(total), 64'(it.total));
        check("main_found", 64'(found), 64'(it.found));
        check("main_busy_done", 64'(busy), 64'd0);
      end
    end
    if (valid8 === 1'b1) begin
      if (q_8.size() == 0) begin
        check("c8_unexpected_valid", 64'(valid8), 64'd0);
      end else begin
        it = q_8.pop_front();
        check("c8_latency", 64'(cyc), 64'(it.cyc));
        check("c8_cx", 64'(cx8), 64'(it.cx));
        check("c8_cy", 64'(cy8), 64'(it.cy));
        check("c8_total", 64'(total8), 64'(it.total));
        check("c8_found", 64'(found8), 64'(it.found));
        check("c8_busy_done", 64'(busy8), 64'd0);
      end
    end
  end

  initial begin
    reset = 1'b1; vs = 1'b1; blank_n = 1'b0; r = 8'd0; g = 8'd0; b = 8'd0;
    xp = '0; yp = '0;
    set_window(8'd200, 8'd255, 8'd0, 8'd50, 8'd0, 8'd50);
    do_reset(3);
    check_zero("reset");

    // Red 4x4 block at x 100..103, y 50..53 on black.
    scan(98, 105, 49, 54, 100, 103, 50, 53, 16, 8'd255, 8'd0, 8'd0);
    vs_low(2);
    check("busy_in_div", 64'(busy), 64'd1);
    check("busy8_in_div", 64'(busy8), 64'd1);
    wait_drain();

    // Same frame with 15 pixels: below threshold.
    scan(98, 105, 49, 54, 100, 103, 50, 53, 15, 8'd255, 8'd0, 8'd0);
    vs_low(2);
    wait_drain();

    // Window boundaries, blanking and VS-low pixels.
    pix(1'b1, 1'b1, 8'd200, 8'd0, 8'd0, 1, 1);
    pix(1'b1, 1'b1, 8'd255, 8'd50, 8'd50, 2, 2);
    pix(1'b1, 1'b1, 8'd199, 8'd0, 8'd0, 3, 3);
    pix(1'b1, 1'b1, 8'd200, 8'd51, 8'd0, 4, 4);
    pix(1'b1, 1'b1, 8'd200, 8'd0, 8'd51, 5, 5);
    pix(1'b1, 1'b0, 8'd220, 8'd10, 8'd10, 6, 6);
    pix(1'b0, 1'b1, 8'd220, 8'd10, 8'd10, 9, 9);
    pix(1'b0, 1'b1, 8'd220, 8'd10, 8'd10, 9, 9);
    wait_drain();

    // Inverted red window: no hits at all.
    set_window(8'd10, 8'd5, 8'd0, 8'd50, 8'd0, 8'd50);
    scan(0, 3, 0, 3, 0, 3, 0, 3, 16, 8'd7, 8'd0, 8'd0);
    vs_low(2);
    wait_drain();

    // 300 hits at (7,3): the CNT_W=8 build saturates at 255.
    set_window(8'd200, 8'd255, 8'd0, 8'd50, 8'd0, 8'd50);
    for (int i = 0; i < 300; i++) pix(1'b1, 1'b1, 8'd230, 8'd20, 8'd20, 7, 3);
    vs_low(2);
    wait_drain();

    // Second VS fall 10 cycles after the first, during the divide.
    scan(10, 19, 20, 21, 10, 19, 20, 21, 20, 8'd240, 8'd5, 8'd5);
    vs_low(2);
    for (int i = 0; i < 8; i++) pix(1'b1, 1'b1, 8'd240, 8'd5, 8'd5, 500, 400);
    vs_low(2);
    check("acc_cnt_cleared", 64'(dut.cnt_r), 64'd0);
    check("acc_sx_cleared", 64'(dut.sum_x_r), 64'd0);
    check("acc_sy_cleared", 64'(dut.sum_y_r), 64'd0);
    check("acc8_cnt_cleared", 64'(dut8.cnt_r), 64'd0);
    wait_drain();
    scan(30, 37, 60, 63, 31, 35, 60, 63, 18, 8'd210, 8'd40, 8'd0);
    vs_low(2);
    wait_drain();

    // Reset in the middle of the divide, then a normal frame.
    scan(98, 105, 49, 54, 100, 103, 50, 53, 16, 8'd255, 8'd0, 8'd0);
    vs_low(1);
    idle(19);
    do_reset(2);
    check_zero("mid_div_reset");
    idle(50);
    scan(200, 209, 100, 103, 201, 208, 100, 102, 24, 8'd250, 8'd30, 8'd30);
    vs_low(2);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
